pc_addr_unit: RTL and testbench
===============================

# pc_addr_unit

Parametrised program-counter and memory-address unit for the simple RISC machine. It replaces the fixed 9-bit PC, the branch adders, the PC mux and the data-address register around the CPU core. It adds configurable address/data width, absolute and relative call/return, and a hardware return-address stack (RAS) with overflow/underflow reporting. It sits between the controller FSM, the datapath and the memory address bus.

## Interface
Parameters:
- AW, 9: address width (PC, data address, RAS entries).
- DW, 16: datapath word width (imm, rd_val, data_in).
- RAS_DEPTH, 4: return-address stack entries, ≥2, power of two.
- START_ADDR, 0: PC value after reset.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- pc_en  in  1  PC update strobe; pc_cmd acts only when high.
- pc_cmd  in  3  0 INC, 1 BR_REL, 2 JMP_ABS, 3 CALL_REL, 4 CALL_ABS, 5 RET, 6/7 treated as INC.
- imm  in  DW  sign-extended branch offset (sximm8 from decoder).
- rd_val  in  DW  register-file read value, absolute target.
- load_addr  in  1  capture data_in[AW-1:0] into data address register.
- data_in  in  DW  datapath result.
- addr_sel  in  1  1: mem_addr = pc; 0: mem_addr = data address register.
- clr_err  in  1  clears sticky RAS flags.
- pc  out  AW  current program counter.
- link  out  AW  pc+1, combinational, for R7 writeback.
- mem_addr  out  AW  memory address bus, combinational.
- ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries.
- ras_overflow  out  1  sticky: push while full.
- ras_underflow  out  1  sticky: pop while empty.

## Operation
- next = pc+1, modulo 2^AW. imm and rd_val are truncated to AW bits. All sums are modulo 2^AW, with no carry out.
- On pc_en, pc loads:
  - INC: next.
  - BR_REL: next + imm.
  - JMP_ABS: rd_val.
  - CALL_REL: next + imm, and pushes next.
  - CALL_ABS: rd_val, and pushes next.
  - RET: the top of the RAS, which is popped.
- RAS is circular storage with a top pointer and a count.
- Push while full: overwrite the oldest entry; count stays RAS_DEPTH; ras_overflow set.
- Pop while empty: pc loads next (acts as INC); count stays 0; ras_underflow set.
- pc_en low: pc and RAS hold, whatever pc_cmd is.
- load_addr is independent of pc_en. Both may occur in the same cycle.
- clr_err clears both flags next edge. A new error event in the same cycle wins over clr_err.
- Reset (reset==0 at an edge):
  - pc=START_ADDR, data address=0, ras_count=0, both flags 0.
  - RAS contents are don't-care.
  - Reset overrides every other input, including a CALL/RET in progress.

## Timing
- pc, data address, RAS and flags update on the rising clk edge only.
- link and mem_addr are combinational from the registered state and addr_sel.
- Latency: a command issued with pc_en in cycle n is visible on pc in cycle n+1. A RET directly after a CALL returns the just-pushed address, with no bubble.
- Controller holds pc_en for exactly one cycle per instruction. Back-to-back strobes are legal, and each is a full update.
- No handshake: the unit is always ready.

## Test plan
- Reset then INC ×3 at AW=9, START_ADDR=0 -> pc 0,1,2,3; set pc=511 via JMP_ABS, then INC -> pc=0, no flags.
- pc=0x010, BR_REL with imm=16'hFFFE -> pc=0x00F; imm=16'h0005 -> pc=next+5.
- pc=0x020, CALL_ABS with rd_val=0x100 -> pc=0x100, link was 0x021, ras_count=1; RET -> pc=0x021, ras_count=0.
- RAS_DEPTH=4, five CALL_REL -> ras_overflow=1, ras_count=4; four RETs return the last four pushed addresses in LIFO order; fifth RET -> pc=pc+1, ras_underflow=1; clr_err -> both 0.
- load_addr with data_in=0x1A5 and pc_en INC in the same cycle -> data address=0x1A5, pc advanced; addr_sel=0 -> mem_addr=0x1A5; addr_sel=1 -> mem_addr=pc.
- Assert reset in the same cycle as a pc_en CALL -> pc=START_ADDR, ras_count=0, flags 0, no push.

Source files
------------

// File: rtl/pc_addr_unit.sv
// pc_addr_unit: program counter, branch/call target selection, hardware
// return-address stack and data-address register for the RISC core.
// All state moves on the rising clk edge; link and mem_addr are purely
// combinational views of the registered state.
module pc_addr_unit #(
    parameter int AW         = 9,
    parameter int DW         = 16,
    parameter int RAS_DEPTH  = 4,
    parameter int START_ADDR = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         pc_en,
    input  logic [2:0]                   pc_cmd,
    input  logic [DW-1:0]                imm,
    input  logic [DW-1:0]                rd_val,
    input  logic                         load_addr,
    input  logic [DW-1:0]                data_in,
    input  logic                         addr_sel,
    input  logic                         clr_err,
    output logic [AW-1:0]                pc,
    output logic [AW-1:0]                link,
    output logic [AW-1:0]                mem_addr,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_overflow,
    output logic                         ras_underflow
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    // Controller command encoding; 6 and 7 fall through to INC.
    typedef enum logic [2:0] {
        CMD_INC      = 3'd0,
        CMD_BR_REL   = 3'd1,
        CMD_JMP_ABS  = 3'd2,
        CMD_CALL_REL = 3'd3,
        CMD_CALL_ABS = 3'd4,
        CMD_RET      = 3'd5
    } pc_cmd_e;

    // Decoded stack operation for the current cycle.
    typedef struct packed {
        logic push;      // write next into the slot above top
        logic pop;       // RET with a valid entry available
        logic ovf_ev;    // push while full
        logic unf_ev;    // RET while empty
    } ras_op_t;

    // Registered state
    logic [AW-1:0] pc_q;
    logic [AW-1:0] daddr_q;
    logic [AW-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0] top_q;
    logic [CW-1:0] cnt_q;
    logic          ovf_q;
    logic          unf_q;

    // Next-state / datapath
    logic [AW-1:0] nxt;
    logic [AW-1:0] rel_tgt;
    logic [AW-1:0] abs_tgt;
    logic [AW-1:0] ras_top;
    logic [AW-1:0] pc_d;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] top_d;
    logic [CW-1:0] cnt_d;
    logic          full;
    logic          empty;
    ras_op_t       op;

    // Only the low AW bits of the wide operands matter; the rest is
    // intentionally dropped (all address arithmetic is modulo 2^AW).
    generate
        if (DW > AW) begin : g_trunc
            logic unused_hi;
            assign unused_hi = ^{imm[DW-1:AW], rd_val[DW-1:AW], data_in[DW-1:AW]};
        end
    endgenerate

    // Target adders and stack status
    always_comb begin
        nxt     = pc_q + AW'(1);
        rel_tgt = nxt + imm[AW-1:0];
        abs_tgt = rd_val[AW-1:0];
        ras_top = ras_mem[top_q];
        full    = (cnt_q == CW'(RAS_DEPTH));
        empty   = (cnt_q == '0);
        // Power-of-two depth lets the pointer wrap for free; when full this
        // slot holds the oldest entry, which is what gets overwritten.
        wr_ptr  = top_q + PW'(1);
    end

    // PC mux and stack operation decode
    always_comb begin
        pc_d = pc_q;
        op   = '0;
        if (pc_en) begin
            case (pc_cmd_e'(pc_cmd))
                CMD_BR_REL:  pc_d = rel_tgt;
                CMD_JMP_ABS: pc_d = abs_tgt;
                CMD_CALL_REL: begin
                    pc_d    = rel_tgt;
                    op.push = 1'b1;
                end
                CMD_CALL_ABS: begin
                    pc_d    = abs_tgt;
                    op.push = 1'b1;
                end
                CMD_RET: begin
                    if (empty) begin
                        // Nothing to return to: behave as INC and report.
                        pc_d      = nxt;
                        op.unf_ev = 1'b1;
                    end else begin
                        pc_d   = ras_top;
                        op.pop = 1'b1;
                    end
                end
                default:     pc_d = nxt;
            endcase
        end
        op.ovf_ev = op.push & full;
    end

    // Stack pointer and occupancy update
    always_comb begin
        top_d = top_q;
        cnt_d = cnt_q;
        if (op.push) begin
            top_d = wr_ptr;
            cnt_d = full ? cnt_q : cnt_q + CW'(1);
        end else if (op.pop) begin
            top_d = top_q - PW'(1);
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Control state: PC, data address, stack pointer/count, sticky flags.
    // A new error event takes priority over clr_err.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q    <= AW'(START_ADDR);
            daddr_q <= '0;
            top_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            top_q <= top_d;
            cnt_q <= cnt_d;
            ovf_q <= op.ovf_ev | (ovf_q & ~clr_err);
            unf_q <= op.unf_ev | (unf_q & ~clr_err);
            if (load_addr) daddr_q <= data_in[AW-1:0];
        end
    end

    // Return-address storage; contents need no reset, but a push coinciding
    // with reset is suppressed so reset truly overrides the CALL.
    always_ff @(posedge clk) begin
        if (reset && op.push) ras_mem[wr_ptr] <= nxt;
    end

    assign pc            = pc_q;
    assign link          = nxt;
    assign mem_addr      = addr_sel ? pc_q : daddr_q;
    assign ras_count     = cnt_q;
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;

endmodule

// File: tb/tb_pc_addr_unit.sv
// Testbench for pc_addr_unit: directed table of the documented corner
// cases, then randomized traffic against a queue-based reference model.
module tb_pc_addr_unit;

    localparam int AW = 9;
    localparam int DW = 16;
    localparam int RAS_DEPTH = 4;
    localparam int START_ADDR = 0;
    localparam int MOD = 512;

    logic          clk = 1'b0;
    logic          reset;
    logic          pc_en;
    logic [2:0]    pc_cmd;
    logic [DW-1:0] imm;
    logic [DW-1:0] rd_val;
    logic          load_addr;
    logic [DW-1:0] data_in;
    logic          addr_sel;
    logic          clr_err;
    logic [AW-1:0] pc;
    logic [AW-1:0] link;
    logic [AW-1:0] mem_addr;
    logic [2:0]    ras_count;
    logic          ras_overflow;
    logic          ras_underflow;

    pc_addr_unit #(.AW(AW), .DW(DW), .RAS_DEPTH(RAS_DEPTH), .START_ADDR(START_ADDR)) dut (
        .clk(clk), .reset(reset), .pc_en(pc_en), .pc_cmd(pc_cmd), .imm(imm),
        .rd_val(rd_val), .load_addr(load_addr), .data_in(data_in),
        .addr_sel(addr_sel), .clr_err(clr_err), .pc(pc), .link(link),
        .mem_addr(mem_addr), .ras_count(ras_count),
        .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        r;
        bit        en;
        bit [2:0]  cmd;
        bit [15:0] im;
        bit [15:0] rd;
        bit        ld;
        bit [15:0] din;
        bit        as;
        bit        clr;
        int        pc;
        int        cnt;
        int        ovf;
        int        unf;
        int        mem;
    } vec_t;

    vec_t tbl[$];
    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int m_pc;
    int m_da;
    bit m_ovf;
    bit m_unf;
    int m_q[$];

    function automatic vec_t v(bit r, bit en, bit [2:0] cmd, bit [15:0] im, bit [15:0] rd,
                               bit ld, bit [15:0] din, bit as, bit clr,
                               int epc, int ecnt, int eovf, int eunf, int emem);
        vec_t t;
        t.r = r; t.en = en; t.cmd = cmd; t.im = im; t.rd = rd; t.ld = ld;
        t.din = din; t.as = as; t.clr = clr;
        t.pc = epc; t.cnt = ecnt; t.ovf = eovf; t.unf = eunf; t.mem = emem;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: stack is a queue, newest at the back, oldest
    // dropped from the front when it grows past RAS_DEPTH.
    task automatic model_step(input vec_t t);
        int nxt;
        bit oe;
        bit ue;
        if (!t.r) begin
            m_pc = START_ADDR; m_da = 0; m_ovf = 0; m_unf = 0;
            m_q.delete();
            return;
        end
        oe = 0; ue = 0;
        nxt = (m_pc + 1) % MOD;
        if (t.ld) m_da = t.din % MOD;
        if (t.en) begin
            case (t.cmd)
                3'd1: m_pc = (nxt + t.im) % MOD;
                3'd2: m_pc = t.rd % MOD;
                3'd3, 3'd4: begin
                    m_q.push_back(nxt);
                    if (m_q.size() > RAS_DEPTH) begin
                        void'(m_q.pop_front());
                        oe = 1;
                    end
                    m_pc = (t.cmd == 3'd3) ? (nxt + t.im) % MOD : t.rd % MOD;
                end
                3'd5: begin
                    if (m_q.size() == 0) begin
                        ue = 1;
                        m_pc = nxt;
                    end else begin
                        m_pc = m_q.pop_back();
                    end
                end
                default: m_pc = nxt;
            endcase
        end
        m_ovf = oe | (m_ovf & !t.clr);
        m_unf = ue | (m_unf & !t.clr);
    endtask

    task automatic apply(input vec_t t);
        @(negedge clk);
        reset = t.r; pc_en = t.en; pc_cmd = t.cmd; imm = t.im; rd_val = t.rd;
        load_addr = t.ld; data_in = t.din; addr_sel = t.as; clr_err = t.clr;
        model_step(t);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t t;
        reset = 1'b0; pc_en = 1'b0; pc_cmd = 3'd0; imm = '0; rd_val = '0;
        load_addr = 1'b0; data_in = '0; addr_sel = 1'b1; clr_err = 1'b0;
        m_pc = START_ADDR; m_da = 0; m_ovf = 0; m_unf = 0;

        //            r en cmd im        rd        ld din      as clr  pc     cnt ovf unf mem
        tbl.push_back(v(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0, 'h000, 0, 0, 0, 'h000));
        tbl.push_back(v(1, 1, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0, 'h001, 0, 0, 0, 'h001));
        tbl.push_back(v(1, 1, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0, 'h002, 0, 0, 0, 'h002));
        tbl.push_back(v(1, 1, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0, 'h003, 0, 0, 0, 'h003));
        tbl.push_back(v(1, 1, 2, 16'h0000, 16'h01FF, 0, 16'h0000, 1, 0, 'h1FF, 0, 0, 0, 'h1FF));
        tbl.push_back(v(1, 1, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0, 'h000, 0, 0, 0, 'h000));
        tbl.push_back(v(1, 1, 2, 16'h0000, 16'h0010, 0, 16'h0000, 1, 0, 'h010, 0, 0, 0, 'h010));
        tbl.push_back(v(1, 1, 1, 16'hFFFE, 16'h0000, 0, 16'h0000, 1, 0, 'h00F, 0, 0, 0, 'h00F));
        tbl.push_back(v(1, 1, 1, 16'h0005, 16'h0000, 0, 16'h0000, 1, 0, 'h015, 0, 0, 0, 'h015));
        tbl.push_back(v(1, 1, 2, 16'h0000, 16'h0020, 0, 16'h0000, 1, 0, 'h020, 0, 0, 0, 'h020));
        tbl.push_back(v(1, 1, 4, 16'h0000, 16'h0100, 0, 16'h0000, 1, 0, 'h100, 1, 0, 0, 'h100));
        tbl.push_back(v(1, 1, 5, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0, 'h021, 0, 0, 0, 'h021));
        // five relative calls: the fifth overwrites the oldest (0x022)
        tbl.push_back(v(1, 1, 3, 16'h0010, 16'h0000, 0, 16'h0000, 1, 0, 'h032, 1, 0, 0, 'h032));
        tbl.push_back(v(1, 1, 3, 16'h0010, 16'h0000, 0, 16'h0000, 1, 0, 'h043, 2, 0, 0, 'h043));
        tbl.push_back(v(1, 1, 3, 16'h0010, 16'h0000, 0, 16'h0000, 1, 0, 'h054, 3, 0, 0, 'h054));
        tbl.push_back(v(1, 1, 3, 16'h0010, 16'h0000, 0, 16'h0000, 1, 0, 'h065, 4, 0, 0, 'h065));
        tbl.push_back(v(1, 1, 3, 16'h0010, 16'h0000, 0, 16'h0000, 1, 0, 'h076, 4, 1, 0, 'h076));
        tbl.push_back(v(1, 1, 5, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0, 'h066, 3, 1, 0, 'h066));
        tbl.push_back(v(1, 1, 5, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0, 'h055, 2, 1, 0, 'h055));
        tbl.push_back(v(1, 1, 5, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0, 'h044, 1, 1, 0, 'h044));
        tbl.push_back(v(1, 1, 5, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0, 'h033, 0, 1, 0, 'h033));
        tbl.push_back(v(1, 1, 5, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0, 'h034, 0, 1, 1, 'h034));
        tbl.push_back(v(1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 1, 'h034, 0, 0, 0, 'h034));
        tbl.push_back(v(1, 0, 4, 16'h0000, 16'h0001, 0, 16'h0000, 1, 0, 'h034, 0, 0, 0, 'h034));
        tbl.push_back(v(1, 1, 0, 16'h0000, 16'h0000, 1, 16'h01A5, 0, 0, 'h035, 0, 0, 0, 'h1A5));
        tbl.push_back(v(1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0, 'h035, 0, 0, 0, 'h035));
        tbl.push_back(v(1, 1, 4, 16'h0000, 16'h0080, 0, 16'h0000, 1, 0, 'h080, 1, 0, 0, 'h080));
        tbl.push_back(v(0, 1, 4, 16'h0000, 16'h0100, 1, 16'h0077, 0, 0, 'h000, 0, 0, 0, 'h000));
        tbl.push_back(v(1, 1, 5, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0, 'h001, 0, 0, 1, 'h001));
        tbl.push_back(v(1, 1, 5, 16'h0000, 16'h0000, 0, 16'h0000, 1, 1, 'h002, 0, 0, 1, 'h002));
        tbl.push_back(v(1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 1, 'h002, 0, 0, 0, 'h002));
        tbl.push_back(v(1, 0, 0, 16'h0000, 16'h0000, 1, 16'hFEA5, 0, 0, 'h002, 0, 0, 0, 'h0A5));
        tbl.push_back(v(1, 1, 2, 16'h0000, 16'hFE10, 0, 16'h0000, 1, 0, 'h010, 0, 0, 0, 'h010));

        foreach (tbl[i]) begin
            apply(tbl[i]);
            chk($sformatf("tbl%0d pc", i),   pc,            tbl[i].pc);
            chk($sformatf("tbl%0d link", i), link,          (tbl[i].pc + 1) % MOD);
            chk($sformatf("tbl%0d mem", i),  mem_addr,      tbl[i].mem);
            chk($sformatf("tbl%0d cnt", i),  ras_count,     tbl[i].cnt);
            chk($sformatf("tbl%0d ovf", i),  ras_overflow,  tbl[i].ovf);
            chk($sformatf("tbl%0d unf", i),  ras_underflow, tbl[i].unf);
        end

        // CALL immediately followed by RET: no bubble between them.
        t = v(1, 1, 4, 0, 16'h0123, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        apply(t);
        t = v(1, 1, 5, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        apply(t);
        chk("call_ret pc", pc, 'h011);
        chk("call_ret cnt", ras_count, 0);

        // Randomized traffic against the reference model
        for (int k = 0; k < 3000; k++) begin
            t.r   = ($urandom_range(0, 99) != 0);
            t.en  = ($urandom_range(0, 3) != 0);
            t.cmd = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) t.cmd = 3'($urandom_range(3, 5));
            t.im  = 16'($urandom);
            if ($urandom_range(0, 1) == 0) t.im = {{8{t.im[7]}}, t.im[7:0]};
            t.rd  = 16'($urandom);
            t.ld  = ($urandom_range(0, 3) == 0);
            t.din = 16'($urandom);
            t.as  = 1'($urandom_range(0, 1));
            t.clr = ($urandom_range(0, 15) == 0);
            apply(t);
            chk("rnd pc",   pc,            m_pc);
            chk("rnd link", link,          (m_pc + 1) % MOD);
            chk("rnd mem",  mem_addr,      t.as ? m_pc : m_da);
            chk("rnd cnt",  ras_count,     m_q.size());
            chk("rnd ovf",  ras_overflow,  m_ovf);
            chk("rnd unf",  ras_underflow, m_unf);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
